// File: rtl/light_pkg.sv
// Shared level encodings and types for the multi-zone light controller.
package light_pkg;

  typedef logic [1:0] level_t;

  localparam level_t LIGHTS_OFF      = 2'd0;
  localparam level_t LOW_LUMINOSITY  = 2'd1;
  localparam level_t MID_LUMINOSITY  = 2'd2;
  localparam level_t HIGH_LUMINOSITY = 2'd3;

  localparam int COLOR_COUNT = 4;
  localparam int COLOR_W     = $clog2(COLOR_COUNT);

endpackage

// File: rtl/light_zone.sv
// One zone: raw level compare, hysteresis target, ramped luminosity, colour counter.
// Optional LIGHT_OVERRIDE_EN adds a direct level override per zone.
module light_zone
  import light_pkg::*;
#(
  parameter int SENSOR_W = 8,
  parameter int T_HIGH   = 15,
  parameter int T_MID    = 30,
  parameter int T_LOW    = 50,
  parameter int HYST     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                color_button,
  input  logic [SENSOR_W-1:0] sensor,
`ifdef LIGHT_OVERRIDE_EN
  input  logic                override_en,
  input  level_t              override_level,
`endif
  output level_t              luminosity,
  output logic [COLOR_W-1:0]  color,
  output logic                settled
);

  // One extra bit so threshold+margin never wraps back into the sensor range.
  localparam logic [SENSOR_W:0] TH_HIGH  = (SENSOR_W+1)'(T_HIGH);
  localparam logic [SENSOR_W:0] TH_MID   = (SENSOR_W+1)'(T_MID);
  localparam logic [SENSOR_W:0] TH_LOW   = (SENSOR_W+1)'(T_LOW);
  localparam logic [SENSOR_W:0] DIM_HIGH = (SENSOR_W+1)'(T_HIGH + HYST);
  localparam logic [SENSOR_W:0] DIM_MID  = (SENSOR_W+1)'(T_MID + HYST);
  localparam logic [SENSOR_W:0] DIM_LOW  = (SENSOR_W+1)'(T_LOW + HYST);

  logic [SENSOR_W:0]   sample_s;
  logic [SENSOR_W:0]   dim_limit_s;
  level_t              raw_s;
  level_t              next_target_s;
  level_t              next_lum_s;
  level_t              target_r;
  level_t              lum_r;
  logic                btn_prev_r;
  logic [COLOR_W-1:0]  color_r;

  assign sample_s = {1'b0, sensor};

  // Raw level from contiguous threshold bands.
  always_comb begin
    if (sample_s < TH_HIGH) begin
      raw_s = HIGH_LUMINOSITY;
    end else if (sample_s < TH_MID) begin
      raw_s = MID_LUMINOSITY;
    end else if (sample_s < TH_LOW) begin
      raw_s = LOW_LUMINOSITY;
    end else begin
      raw_s = LIGHTS_OFF;
    end
  end

  // Sensor level needed to leave the current target band when dimming.
  always_comb begin
    case (target_r)
      HIGH_LUMINOSITY: dim_limit_s = DIM_HIGH;
      MID_LUMINOSITY:  dim_limit_s = DIM_MID;
      LOW_LUMINOSITY:  dim_limit_s = DIM_LOW;
      default:         dim_limit_s = {(SENSOR_W+1){1'b1}};
    endcase
  end

  // Brighten at once; dim only past the hysteresis margin.
  always_comb begin
    next_target_s = target_r;
    if (raw_s > target_r) begin
      next_target_s = raw_s;
    end else if ((raw_s < target_r) && (sample_s >= dim_limit_s)) begin
      next_target_s = raw_s;
    end else begin
      next_target_s = target_r;
    end
  end

  // One step toward the current target per tick.
  always_comb begin
    next_lum_s = lum_r;
    if (tick && (lum_r < target_r)) begin
      next_lum_s = lum_r + 2'd1;
    end else if (tick && (lum_r > target_r)) begin
      next_lum_s = lum_r - 2'd1;
    end else begin
      next_lum_s = lum_r;
    end
  end

  // Target and driven level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_r <= LIGHTS_OFF;
      lum_r    <= LIGHTS_OFF;
`ifdef LIGHT_OVERRIDE_EN
    end else if (override_en) begin
      target_r <= override_level;
      lum_r    <= override_level;
`endif
    end else begin
      target_r <= next_target_s;
      lum_r    <= next_lum_s;
    end
  end

  // Colour advances once per button rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev_r <= 1'b0;
      color_r    <= {COLOR_W{1'b0}};
    end else begin
      btn_prev_r <= color_button;
      if (color_button && !btn_prev_r) begin
        color_r <= color_r + COLOR_W'(1);
      end else begin
        color_r <= color_r;
      end
    end
  end

  assign luminosity = lum_r;
  assign color      = color_r;
`ifdef LIGHT_OVERRIDE_EN
  assign settled    = override_en | (lum_r == target_r);
`else
  assign settled    = (lum_r == target_r);
`endif

endmodule

// File: rtl/light_control_multi.sv
// Multi-zone light controller: shared ramp prescaler plus one light_zone per zone.
// Optional LIGHT_OVERRIDE_EN adds override_en / override_level ports.
module light_control_multi
  import light_pkg::*;
#(
  parameter int ZONES    = 4,
  parameter int SENSOR_W = 8,
  parameter int T_HIGH   = 15,
  parameter int T_MID    = 30,
  parameter int T_LOW    = 50,
  parameter int HYST     = 2,
  parameter int RAMP_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ZONES-1:0]          color_button,
  input  logic [ZONES*SENSOR_W-1:0] sunlight_sensor,
`ifdef LIGHT_OVERRIDE_EN
  input  logic [ZONES-1:0]          override_en,
  input  logic [ZONES*2-1:0]        override_level,
`endif
  output logic [ZONES*2-1:0]        luminosity,
  output logic [ZONES*2-1:0]        color,
  output logic [ZONES-1:0]          settled
);

  // A one-cycle divider still needs a 1-bit counter that never leaves zero.
  localparam int              CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] presc_r;
  logic             tick_s;

  assign tick_s = (presc_r == CNT_LAST);

  // Shared ramp prescaler, wraps on the terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      presc_r <= {CNT_W{1'b0}};
    end else begin
      presc_r <= presc_r + CNT_W'(1);
    end
  end

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    light_zone #(
      .SENSOR_W (SENSOR_W),
      .T_HIGH   (T_HIGH),
      .T_MID    (T_MID),
      .T_LOW    (T_LOW),
      .HYST     (HYST)
    ) u_zone (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick_s),
      .color_button   (color_button[z]),
      .sensor         (sunlight_sensor[z*SENSOR_W +: SENSOR_W]),
`ifdef LIGHT_OVERRIDE_EN
      .override_en    (override_en[z]),
      .override_level (override_level[z*2 +: 2]),
`endif
      .luminosity     (luminosity[z*2 +: 2]),
      .color          (color[z*2 +: 2]),
      .settled        (settled[z])
    );
  end

endmodule

// File: tb/tb_light_control_multi.sv
// Directed self-checking bench for light_control_multi (RAMP_DIV=4, 4 zones).
module tb_light_control_multi;

  localparam int ZONES    = 4;
  localparam int SENSOR_W = 8;
  localparam int RAMP_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  color_button = 4'd0;
  logic [31:0] sunlight_sensor = {4{8'd100}};
  logic [7:0]  luminosity;
  logic [7:0]  color;
  logic [3:0]  settled;
`ifdef LIGHT_OVERRIDE_EN
  logic [3:0]  override_en = 4'd0;
  logic [7:0]  override_level = 8'd0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  light_control_multi #(
    .ZONES    (ZONES),
    .SENSOR_W (SENSOR_W),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .color_button    (color_button),
    .sunlight_sensor (sunlight_sensor),
`ifdef LIGHT_OVERRIDE_EN
    .override_en     (override_en),
    .override_level  (override_level),
`endif
    .luminosity      (luminosity),
    .color           (color),
    .settled         (settled)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sensor(input int z, input int v);
    sunlight_sensor[z*8 +: 8] = 8'(v);
  endtask

  function automatic int lum(input int z);
    return int'(luminosity[z*2 +: 2]);
  endfunction

  initial begin
    step(2);
    check("rst_lum", int'(luminosity), 0);
    check("rst_color", int'(color), 0);
    check("rst_settled", int'(settled), 15);

    // Ramp up zone 0: ticks on edges 4, 8, 12 after release
    reset = 1'b1;
    set_sensor(0, 10);
    step(1);
    check("tgt_settled0", int'(settled[0]), 0);
    check("tgt_lum0", lum(0), 0);
    step(2);
    check("e3_lum0", lum(0), 0);
    step(1);
    check("e4_lum0", lum(0), 1);
    step(4);
    check("e8_lum0", lum(0), 2);
    check("e8_settled0", int'(settled[0]), 0);
    step(3);
    check("e11_lum0", lum(0), 2);
    step(1);
    check("e12_lum0", lum(0), 3);
    check("e12_settled0", int'(settled[0]), 1);

    // Band boundaries
    set_sensor(1, 15);
    set_sensor(2, 30);
    set_sensor(3, 50);
    step(1);
    check("b15_settled1", int'(settled[1]), 0);
    check("b30_settled2", int'(settled[2]), 0);
    check("b50_settled3", int'(settled[3]), 1);
    step(11);
    check("b15_mid", lum(1), 2);
    check("b30_low", lum(2), 1);
    check("b50_off", lum(3), 0);
    check("b_settled", int'(settled[3:1]), 7);
    set_sensor(2, 14);
    set_sensor(3, 49);
    step(4);
    check("b14_step", lum(2), 2);
    check("b49_low", lum(3), 1);
    step(4);
    check("b14_high", lum(2), 3);

    // Hysteresis on zone 0 (target HIGH)
    set_sensor(0, 16);
    step(4);
    check("hyst16_lum", lum(0), 3);
    check("hyst16_settled", int'(settled[0]), 1);
    set_sensor(0, 17);
    step(1);
    check("hyst17_settled", int'(settled[0]), 0);
    step(3);
    check("hyst17_lum", lum(0), 2);
    check("hyst17_settled2", int'(settled[0]), 1);
    set_sensor(0, 14);
    step(1);
    check("hyst14_settled", int'(settled[0]), 0);
    step(3);
    check("hyst14_lum", lum(0), 3);

    // Colour pulses on zone 2
    for (int i = 0; i < 5; i++) begin
      color_button[2] = 1'b1;
      step(1);
      check("color2_pulse", int'(color[5:4]), (i + 1) % 4);
      color_button[2] = 1'b0;
      step(1);
    end
    check("color_others", int'(color & 8'hCF), 0);
    color_button[2] = 1'b1;
    step(20);
    check("color2_held", int'(color[5:4]), 2);
    color_button[2] = 1'b0;
    step(1);

    // Target drops on a tick edge: the step still uses the old target
    set_sensor(0, 100);
    step(1);
    check("simul_lum0", lum(0), 3);
    check("simul_settled0", int'(settled[0]), 0);
    step(4);
    check("dim_lum0", lum(0), 2);

    // Asynchronous reset mid-ramp, away from the clock edge
    #3;
    reset = 1'b0;
    #1;
    check("arst_lum", int'(luminosity), 0);
    check("arst_color", int'(color), 0);
    check("arst_settled", int'(settled), 15);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(3);
    check("presc_r3_lum1", lum(1), 0);
    step(1);
    check("presc_r4_lum1", lum(1), 1);

`ifdef LIGHT_OVERRIDE_EN
    override_en[1] = 1'b1;
    override_level[3:2] = 2'd2;
    set_sensor(1, 100);
    step(1);
    check("ovr_lum1", lum(1), 2);
    check("ovr_settled1", int'(settled[1]), 1);
    override_en[1] = 1'b0;
    step(2);
    check("ovr_hold_lum1", lum(1), 2);
    check("ovr_rel_settled1", int'(settled[1]), 0);
    step(1);
    check("ovr_step1", lum(1), 1);
    step(4);
    check("ovr_step0", lum(1), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/light_control_multi.md
Name: light_control_multi

Overview:
- Multi-zone successor to the single-zone light controller.
- Each of ZONES zones has its own sunlight sensor and colour button.
- Per zone, the block derives a target luminosity from programmable thresholds with hysteresis, then ramps the driven luminosity one step at a time toward that target.
- Sits between the sensor front-end and the lamp drivers.

Parameters:
- ZONES, 4, number of independent zones (1..16).
- SENSOR_W, 8, sensor sample width.
- T_HIGH, 15, sensor below this selects HIGH.
- T_MID, 30, sensor below this selects MID.
- T_LOW, 50, sensor below this selects LOW; at or above it selects OFF.
- HYST, 2, hysteresis margin in sensor LSBs applied on dimming transitions.
- RAMP_DIV, 1000, clock cycles per ramp step (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- color_button  in  ZONES  per-zone colour button, synchronous level.
- sunlight_sensor  in  ZONES*SENSOR_W  packed per-zone samples; zone z occupies bits [z*SENSOR_W +: SENSOR_W].
- luminosity  out  ZONES*2  packed driven level per zone: 3=HIGH, 2=MID, 1=LOW, 0=OFF.
- color  out  ZONES*2  packed colour index per zone.
- settled  out  ZONES  1 when a zone's luminosity equals its target.

Behaviour:
- Reset (reset=0, asynchronous):
  - luminosity=0, color=0, target=0, settled=1.
  - Ramp prescaler=0; button history=0.
- Raw level, per zone, unsigned compare:
  - s<T_HIGH gives 3.
  - s<T_MID gives 2.
  - s<T_LOW gives 1.
  - otherwise 0.
  - Bands are contiguous: s==T_HIGH gives MID, s==T_MID gives LOW. No gaps.
- Target register (1-cycle latency from sensor):
  - Brighten: if raw>target, target<=raw immediately.
  - Dim: if raw<target, target<=raw only when s >= U(target)+HYST, where U(3)=T_HIGH, U(2)=T_MID, U(1)=T_LOW. Otherwise target is held.
  - U+HYST is computed at SENSOR_W+1 bits. No wrap; a sum above the sensor range means the zone never dims out of that band.
  - Dimming jumps directly to raw and may skip levels; the ramp smooths the output.
- Ramp:
  - One shared prescaler counts 0..RAMP_DIV-1; tick asserts on the terminal count, one cycle wide.
  - On tick, each zone with luminosity≠target moves luminosity one step toward target (±1).
  - The level saturates at 0 and 3; it never wraps.
  - RAMP_DIV=1 gives a step every cycle.
- settled = (luminosity==target), combinational from the registers.
- Colour:
  - Per-zone rising-edge detect on color_button (registered previous value).
  - Each edge advances color 0→1→2→3→0 with wrap.
  - A held button advances once only.
  - Colour is independent of luminosity.
- Simultaneous events:
  - A target change on a tick cycle: the step uses the old target; the new target applies from the next tick.
  - Button edges in several zones on the same cycle are all honoured.
- Reset mid-ramp: all zones return to OFF / colour 0 immediately. The prescaler restarts at 0 after release.

Optional Feature:
- Macro: LIGHT_OVERRIDE_EN.
- When defined, adds two ports:
  - override_en, in, ZONES wide.
  - override_level, in, ZONES*2 wide.
- While override_en[z]=1:
  - target and luminosity for zone z load override_level[z] on the next clock, bypassing hysteresis and ramp.
  - settled[z]=1.
- When override_en[z] drops, normal target evaluation resumes the next cycle and luminosity ramps from the override value.
- When the macro is undefined, the ports are absent and the behaviour is exactly as above.

Decomposition:
- Package light_pkg holds:
  - Level encodings: LIGHTS_OFF, LOW_LUMINOSITY, MID_LUMINOSITY, HIGH_LUMINOSITY.
  - Colour count 4.
  - A level_t 2-bit typedef.
- Sub-module light_zone: one zone's raw-level compare, hysteresis target, ramp step, colour counter and settled flag. It takes a tick input.
- The top level holds the shared prescaler and a generate loop over ZONES.

Test Plan:
- Reset then zone0 sensor=10, RAMP_DIV=4 → target=3 after 1 cycle. luminosity 1,2,3 on the next three ticks (cycles 4,8,12). settled rises on the third step.
- Boundaries: sensor=15 → MID, 30 → LOW, 50 → OFF, 49 → LOW, 14 → HIGH.
- Hysteresis: target HIGH, sensor=16 → held HIGH. sensor=17 (=15+2) → target MID. sensor back to 14 → HIGH immediately.
- Colour: 5 single-cycle pulses on color_button[2] → color[2] sequence 1,2,3,0,1. A button held 20 cycles → one increment. Other zones unchanged.
- Reset asserted mid-ramp (luminosity=2, target=0) → outputs 0 asynchronously, before the next clk edge. After release, the next tick occurs RAMP_DIV cycles later.
- With LIGHT_OVERRIDE_EN: override_en[1]=1, level=2 while sensor=100 → luminosity[1]=2 next cycle. On release → steps 2→1→0 on successive ticks.
